// File: rtl/gerenciador_vidas.sv
// gerenciador_vidas: game-level life manager FSM mirroring a 3-bit life counter.
//
// Counts rising edges of the raw hit level as player hits and keeps a mirrored
// life count. It emits one-cycle dec/reload pulses so an external life counter
// stays equal to lives_o. After a non-fatal hit, an optional invulnerability
// window ignores further hits. The FSM flags game over when the last life is lost.
//
// Build option: define GERENCIADOR_GRACE_EN to include the INVULN state and the
// grace timer. Without it, a non-fatal hit returns straight to PLAYING,
// invuln_o is tied low and GRACE_CYCLES/GRACE_W have no effect.
//
// Ports:
//   clock_i      rising-edge system clock
//   reset_i      synchronous, active-high reset
//   start_i      new-game request level (honoured in IDLE and GAME_OVER)
//   hit_i        raw collision level; only its rising edges count
//   lives_o      registered life count
//   cnt_dec_o    one-cycle pulse: decrement the external life counter
//   cnt_rst_o    one-cycle pulse: reload the external life counter
//   invuln_o     high while the grace window is active
//   game_over_o  high in GAME_OVER
//   state_o      IDLE=0 PLAYING=1 INVULN=2 GAME_OVER=3
module gerenciador_vidas #(
    parameter int LIFE_W       = 3,
    parameter int INIT_LIVES   = 7,
    parameter int GRACE_CYCLES = 8,
    parameter int GRACE_W      = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              hit_i,
    output logic [LIFE_W-1:0] lives_o,
    output logic              cnt_dec_o,
    output logic              cnt_rst_o,
    output logic              invuln_o,
    output logic              game_over_o,
    output logic [1:0]        state_o
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PLAYING   = 2'd1;
    localparam logic [1:0] GAME_OVER = 2'd3;
    localparam logic [LIFE_W-1:0] INIT_L = LIFE_W'(INIT_LIVES);
    localparam logic [LIFE_W-1:0] ONE_L  = LIFE_W'(1);

    logic [1:0]        state_q, state_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic              dec_q, dec_d;
    logic              rst_q, rst_d;
    logic              go_q, go_d;
    logic              hit_q;
    logic              hit_edge;

    assign hit_edge = hit_i & ~hit_q;

`ifdef GERENCIADOR_GRACE_EN
    localparam logic [1:0] INVULN = 2'd2;
    localparam logic [GRACE_W-1:0] GRACE_L = GRACE_W'(GRACE_CYCLES);
    logic [GRACE_W-1:0] timer_q, timer_d;
    logic               inv_q, inv_d;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        timer_d = timer_q;
        dec_d   = 1'b0;
        rst_d   = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                lives_d = (state_q == GAME_OVER) ? '0 : lives_q;
                if (start_i) begin
                    state_d = PLAYING;
                    lives_d = INIT_L;
                    rst_d   = 1'b1;
                end
            end
            PLAYING: begin
                // lives_q is never 0 here; the guard keeps dec from ever firing at zero
                if (hit_edge && lives_q != '0) begin
                    dec_d   = 1'b1;
                    lives_d = lives_q - ONE_L;
                    if (lives_q == ONE_L) begin
                        state_d = GAME_OVER;
                    end else if (GRACE_CYCLES != 0) begin
                        state_d = INVULN;
                        timer_d = GRACE_L;
                    end
                end
            end
            INVULN: begin
                // The timer value 1 marks the final grace cycle, so invuln lasts GRACE_CYCLES cycles
                timer_d = timer_q - GRACE_W'(1);
                if (timer_q <= GRACE_W'(1)) begin
                    state_d = PLAYING;
                    timer_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        inv_d = (state_d == INVULN);
        go_d  = (state_d == GAME_OVER);
    end

    always_ff @(posedge clock_i) begin
        hit_q <= hit_i;
        if (reset_i) begin
            state_q <= IDLE;
            lives_q <= INIT_L;
            timer_q <= '0;
            dec_q   <= 1'b0;
            rst_q   <= 1'b0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
            dec_q   <= dec_d;
            rst_q   <= rst_d;
            inv_q   <= inv_d;
            go_q    <= go_d;
        end
    end

    assign invuln_o = inv_q;
`else
    // Grace parameters are only meaningful with the grace window built in
    logic unused_grace;
    assign unused_grace = ^{32'(GRACE_CYCLES), 32'(GRACE_W)};

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        dec_d   = 1'b0;
        rst_d   = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                lives_d = (state_q == GAME_OVER) ? '0 : lives_q;
                if (start_i) begin
                    state_d = PLAYING;
                    lives_d = INIT_L;
                    rst_d   = 1'b1;
                end
            end
            PLAYING: begin
                if (hit_edge && lives_q != '0) begin
                    dec_d   = 1'b1;
                    lives_d = lives_q - ONE_L;
                    state_d = (lives_q == ONE_L) ? GAME_OVER : PLAYING;
                end
            end
            default: state_d = IDLE;
        endcase
        go_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge clock_i) begin
        hit_q <= hit_i;
        if (reset_i) begin
            state_q <= IDLE;
            lives_q <= INIT_L;
            dec_q   <= 1'b0;
            rst_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            dec_q   <= dec_d;
            rst_q   <= rst_d;
            go_q    <= go_d;
        end
    end

    assign invuln_o = 1'b0;
`endif

    assign state_o     = state_q;
    assign lives_o     = lives_q;
    assign cnt_dec_o   = dec_q;
    assign cnt_rst_o   = rst_q;
    assign game_over_o = go_q;
endmodule

// File: tb/tb_gerenciador_vidas.sv
// tb_gerenciador_vidas: directed scoreboard bench for gerenciador_vidas (default params).
module tb_gerenciador_vidas;
    logic       clk = 1'b0;
    logic       reset, start, hit;
    logic [2:0] lives;
    logic       cnt_dec, cnt_rst, invuln, game_over;
    logic [1:0] state;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    bit  done = 1'b0;
    bit  fin = 1'b0;

    typedef struct {
        int         at;
        string      nm;
        logic [1:0] st;
        logic [2:0] lv;
        logic       dec, rst, inv, go;
    } exp_t;

    typedef struct {
        string      nm;
        logic       dec, rst;
        logic [2:0] lv;
    } pul_t;

    exp_t eq[$];
    pul_t pq[$];
    exp_t e;
    pul_t p;

    gerenciador_vidas dut (
        .clock_i    (clk),
        .reset_i    (reset),
        .start_i    (start),
        .hit_i      (hit),
        .lives_o    (lives),
        .cnt_dec_o  (cnt_dec),
        .cnt_rst_o  (cnt_rst),
        .invuln_o   (invuln),
        .game_over_o(game_over),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot checks: every expectation is tagged with the cycle it applies to
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].at <= cyc) begin
            e = eq.pop_front();
            total++;
            if (e.at != cyc || {state, lives, cnt_dec, cnt_rst, invuln, game_over} !==
                {e.st, e.lv, e.dec, e.rst, e.inv, e.go}) begin
                bad++;
                $display("FAIL %s cyc=%0d: got st=%0d lv=%0d dec=%b rst=%b inv=%b go=%b, want st=%0d lv=%0d dec=%b rst=%b inv=%b go=%b",
                         e.nm, cyc, state, lives, cnt_dec, cnt_rst, invuln, game_over,
                         e.st, e.lv, e.dec, e.rst, e.inv, e.go);
            end
        end
        // Pulse checks: every pulse the DUT emits must match the next expected pulse
        if (cnt_dec === 1'b1 || cnt_rst === 1'b1) begin
            total++;
            if (pq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d: got dec=%b rst=%b lv=%0d, want no pulse",
                         cyc, cnt_dec, cnt_rst, lives);
            end else begin
                p = pq.pop_front();
                if ({cnt_dec, cnt_rst, lives} !== {p.dec, p.rst, p.lv}) begin
                    bad++;
                    $display("FAIL pulse_%s cyc=%0d: got dec=%b rst=%b lv=%0d, want dec=%b rst=%b lv=%0d",
                             p.nm, cyc, cnt_dec, cnt_rst, lives, p.dec, p.rst, p.lv);
                end
            end
        end
        if (done && !fin) begin
            total++;
            if (eq.size() != 0 || pq.size() != 0) begin
                bad++;
                $display("FAIL leftover: got %0d snapshots and %0d pulses unseen, want 0 and 0",
                         eq.size(), pq.size());
            end
            fin = 1'b1;
        end
    end

    // Sets the expected outputs after the next clock edge, then advances one cycle
    task automatic nx(input string n, input logic [1:0] st, input logic [2:0] lv,
                      input logic d, input logic r, input logic i, input logic g);
        eq.push_back('{cyc + 1, n, st, lv, d, r, i, g});
        if (d || r) pq.push_back('{n, d, r, lv});
        @(posedge clk);
        #2;
    endtask

`ifdef GERENCIADOR_GRACE_EN
    // Cycles 2..9 after a non-fatal hit: eight invuln cycles, then back to PLAYING
    task automatic grace(input logic [2:0] lv);
        for (int d = 2; d <= 9; d++)
            nx("grace", (d < 9) ? 2'd2 : 2'd1, lv, 1'b0, 1'b0, d < 9, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        // test 1: reset, then start a game
        nx("t1_reset0", 2'd0, 3'd7, 0, 0, 0, 0);
        nx("t1_reset1", 2'd0, 3'd7, 0, 0, 0, 0);
        reset = 1'b0;
        start = 1'b1;
        nx("t1_start", 2'd1, 3'd7, 0, 1, 0, 0);
        start = 1'b0;
        nx("t1_rst_once", 2'd1, 3'd7, 0, 0, 0, 0);
`ifdef GERENCIADOR_GRACE_EN
        // test 2: hit held for 5 cycles, start inside the grace window ignored
        hit = 1'b1;
        nx("t2_hit", 2'd2, 3'd6, 1, 0, 1, 0);
        for (int d = 2; d <= 9; d++) begin
            hit   = (d <= 5);
            start = (d == 4);
            nx("t2_grace", (d < 9) ? 2'd2 : 2'd1, 3'd6, 0, 0, d < 9, 0);
        end
        start = 1'b1;
        nx("t2_start_ignored", 2'd1, 3'd6, 0, 0, 0, 0);
        start = 1'b0;
        // test 3: hits inside the window, on its last cycle, and held past its end
        hit = 1'b1;
        nx("t3_hit", 2'd2, 3'd5, 1, 0, 1, 0);
        for (int d = 2; d <= 10; d++) begin
            hit = (d == 3 || d == 6 || d == 9 || d == 10);
            nx("t3_ignored", (d < 9) ? 2'd2 : 2'd1, 3'd5, 0, 0, d < 9, 0);
        end
        hit = 1'b0;
        nx("t3_release", 2'd1, 3'd5, 0, 0, 0, 0);
        // test 4: separated hits down to game over
        for (int lv = 5; lv >= 1; lv--) begin
            hit = 1'b1;
            nx("t4_hit", (lv > 1) ? 2'd2 : 2'd3, 3'(lv - 1), 1, 0, lv > 1, lv == 1);
            hit = 1'b0;
            if (lv > 1) grace(3'(lv - 1));
        end
`else
        // test 2: hit held for 5 cycles counts once, no grace window
        hit = 1'b1;
        nx("t2_hit", 2'd1, 3'd6, 1, 0, 0, 0);
        for (int d = 2; d <= 9; d++) begin
            hit = (d <= 5);
            nx("t2_hold", 2'd1, 3'd6, 0, 0, 0, 0);
        end
        start = 1'b1;
        nx("t2_start_ignored", 2'd1, 3'd6, 0, 0, 0, 0);
        start = 1'b0;
        // test 6b: a second hit two cycles after the first is counted
        hit = 1'b1;
        nx("t6_hit1", 2'd1, 3'd5, 1, 0, 0, 0);
        hit = 1'b0;
        nx("t6_gap", 2'd1, 3'd5, 0, 0, 0, 0);
        hit = 1'b1;
        nx("t6_hit2", 2'd1, 3'd4, 1, 0, 0, 0);
        hit = 1'b0;
        nx("t6_low", 2'd1, 3'd4, 0, 0, 0, 0);
        reset = 1'b1;
        nx("t6_reset", 2'd0, 3'd7, 0, 0, 0, 0);
        reset = 1'b0;
        hit = 1'b1;
        nx("t6_idle_hit", 2'd0, 3'd7, 0, 0, 0, 0);
        hit   = 1'b0;
        start = 1'b1;
        nx("t6_start", 2'd1, 3'd7, 0, 1, 0, 0);
        start = 1'b0;
        // test 4: seven hits down to game over
        for (int lv = 7; lv >= 1; lv--) begin
            hit = 1'b1;
            nx("t4_hit", (lv > 1) ? 2'd1 : 2'd3, 3'(lv - 1), 1, 0, 0, lv == 1);
            hit = 1'b0;
            nx("t4_gap", (lv > 1) ? 2'd1 : 2'd3, 3'(lv - 1), 0, 0, 0, lv == 1);
        end
`endif
        // further hits after game over change nothing
        hit = 1'b1;
        nx("t4_over_hit", 2'd3, 3'd0, 0, 0, 0, 1);
        hit = 1'b0;
        nx("t4_over_low", 2'd3, 3'd0, 0, 0, 0, 1);
        // test 5: start and a rising hit together in GAME_OVER
        start = 1'b1;
        hit   = 1'b1;
        nx("t5_start_hit", 2'd1, 3'd7, 0, 1, 0, 0);
        start = 1'b0;
        nx("t5_hold", 2'd1, 3'd7, 0, 0, 0, 0);
        hit = 1'b0;
        nx("t5_release", 2'd1, 3'd7, 0, 0, 0, 0);
`ifdef GERENCIADOR_GRACE_EN
        // test 6: reset inside the grace window with four lives left
        hit = 1'b1;
        nx("t6_hit", 2'd2, 3'd6, 1, 0, 1, 0);
        hit = 1'b0;
        grace(3'd6);
        hit = 1'b1;
        nx("t6_hit", 2'd2, 3'd5, 1, 0, 1, 0);
        hit = 1'b0;
        grace(3'd5);
        hit = 1'b1;
        nx("t6_hit", 2'd2, 3'd4, 1, 0, 1, 0);
        hit = 1'b0;
        nx("t6_invuln", 2'd2, 3'd4, 0, 0, 1, 0);
        reset = 1'b1;
        nx("t6_reset", 2'd0, 3'd7, 0, 0, 0, 0);
        reset = 1'b0;
        hit = 1'b1;
        nx("t6_idle_hit", 2'd0, 3'd7, 0, 0, 0, 0);
        hit   = 1'b0;
        start = 1'b1;
        nx("t6_start", 2'd1, 3'd7, 0, 1, 0, 0);
        start = 1'b0;
`endif
        // reset together with a hit edge drops the pending decrement
        hit   = 1'b1;
        reset = 1'b1;
        nx("rd_reset_hit", 2'd0, 3'd7, 0, 0, 0, 0);
        reset = 1'b0;
        start = 1'b1;
        nx("rd_restart", 2'd1, 3'd7, 0, 1, 0, 0);
        start = 1'b0;
        nx("rd_no_edge", 2'd1, 3'd7, 0, 0, 0, 0);
        hit = 1'b0;
        nx("rd_end", 2'd1, 3'd7, 0, 0, 0, 0);
        done = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        if (!fin) begin
            bad++;
            $display("FAIL final_check: got no leftover check, want one");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
